// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared definitions for the 16-bit RISC control unit: opcode
//            numbering (matches the ALU), sequencer state encoding,
//            instruction field positions and opcode class masks.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Opcode numbering shared with the ALU
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_RDMEM = 4'd6;
  localparam logic [3:0] OP_WRMEM = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_JMPA  = 4'd12;
  localparam logic [3:0] OP_JMPR  = 4'd13;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_REGREAD   = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5
  } state_t;

  // Instruction field bit positions
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int ALUOP_MSB = 15;
  localparam int ALUOP_LSB = 11;
  localparam int RD_MSB    = 10;
  localparam int RD_LSB    = 8;
  localparam int RA_MSB    = 7;
  localparam int RA_LSB    = 5;
  localparam int RB_MSB    = 4;
  localparam int RB_LSB    = 2;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 0;

  // Opcode class masks, one bit per opcode value
  localparam logic [15:0] WB_MASK      = 16'h0F7F; // opcodes 0-6, 8-11
  localparam logic [15:0] BRANCH_MASK  = 16'h3000; // JMPA, JMPR
  localparam logic [15:0] MEM_MASK     = 16'h00C0; // Rdmem, Wrmem
  localparam logic [15:0] ILLEGAL_MASK = 16'hC000; // 14, 15

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_if
// Purpose  : Handshake/bus bundle between the control unit and its
//            environment (instruction memory, data memory, ALU, regfile).
// Modports : master - control unit side (drives o_* signals)
//            slave  - environment side (drives i_* signals)
// Revision : 1.0 - initial release
// ============================================================================
interface control_unit_if;
  logic [15:0] i_instr;
  logic        i_fetch_ack;
  logic        i_mem_ack;
  logic        i_shldBranch;
  logic        o_fetch_req;
  logic        o_en_decode;
  logic        o_en_regread;
  logic        o_en_alu;
  logic        o_en_regwrite;
  logic [4:0]  o_aluop;
  logic [7:0]  o_imm;
  logic [2:0]  o_selD;
  logic [2:0]  o_selA;
  logic [2:0]  o_selB;
  logic        o_mem_req;
  logic        o_mem_we;
  logic        o_wb_sel;
  logic        o_pc_load;
  logic        o_illegal;
  logic        o_mem_err;

  modport master (
    input  i_instr, i_fetch_ack, i_mem_ack, i_shldBranch,
    output o_fetch_req, o_en_decode, o_en_regread, o_en_alu, o_en_regwrite,
           o_aluop, o_imm, o_selD, o_selA, o_selB, o_mem_req, o_mem_we,
           o_wb_sel, o_pc_load, o_illegal, o_mem_err
  );

  modport slave (
    output i_instr, i_fetch_ack, i_mem_ack, i_shldBranch,
    input  o_fetch_req, o_en_decode, o_en_regread, o_en_alu, o_en_regwrite,
           o_aluop, o_imm, o_selD, o_selA, o_selB, o_mem_req, o_mem_we,
           o_wb_sel, o_pc_load, o_illegal, o_mem_err
  );
endinterface
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Purpose  : Combinational field extraction and opcode classification.
// Ports    : instr      - 16-bit instruction word
//            aluop/imm/sel_d/sel_a/sel_b - extracted fields
//            is_mem, is_write, is_branch, writes_reg, illegal - class flags
// Revision : 1.0 - initial release
// ============================================================================
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [15:0] instr,
  output logic [4:0]  aluop,
  output logic [7:0]  imm,
  output logic [2:0]  sel_d,
  output logic [2:0]  sel_a,
  output logic [2:0]  sel_b,
  output logic        is_mem,
  output logic        is_write,
  output logic        is_branch,
  output logic        writes_reg,
  output logic        illegal
);
  logic [3:0] opcode;

  assign opcode     = instr[OPC_MSB:OPC_LSB];
  assign aluop      = instr[ALUOP_MSB:ALUOP_LSB];
  assign imm        = instr[IMM_MSB:IMM_LSB];
  assign sel_d      = instr[RD_MSB:RD_LSB];
  assign sel_a      = instr[RA_MSB:RA_LSB];
  assign sel_b      = instr[RB_MSB:RB_LSB];
  assign is_mem     = MEM_MASK[opcode];
  assign is_write   = (opcode == OP_WRMEM);
  assign is_branch  = BRANCH_MASK[opcode];
  assign writes_reg = WB_MASK[opcode];
  assign illegal    = ILLEGAL_MASK[opcode];
endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Multi-cycle sequencer for the 16-bit RISC core. Walks one
//            instruction at a time through FETCH, DECODE, REGREAD, EXECUTE,
//            optional MEM and WRITEBACK, driving registered stage enables.
// Ports    : i_clk   - clock, rising edge
//            i_rst_n - asynchronous active-low reset
//            bus     - control_unit_if.master (fetch/mem handshakes, ALU
//                      controls, register selects, status strobes)
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  control_unit_if.master bus
);
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, next_state;
  logic [15:0] instr_q;
  logic [7:0]  mem_cnt;
  logic        timeout;

  logic [15:0] cur_instr;
  logic [4:0]  d_aluop;
  logic [7:0]  d_imm;
  logic [2:0]  d_sel_d, d_sel_a, d_sel_b;
  logic        d_is_mem, d_is_write, d_is_branch, d_writes_reg, d_illegal;

  logic        fetch_req, en_decode, en_regread, en_alu, en_regwrite;
  logic [4:0]  aluop;
  logic [7:0]  imm;
  logic [2:0]  sel_d, sel_a, sel_b;
  logic        mem_req, mem_we, wb_sel, pc_load, illegal, mem_err;

  // In FETCH the decoder looks at the incoming word so fields and the
  // illegal strobe can be registered on the ack edge; afterwards it
  // classifies the latched word.
  assign cur_instr = (state == ST_FETCH) ? bus.i_instr : instr_q;

  instr_decoder u_dec (
    .instr      (cur_instr),
    .aluop      (d_aluop),
    .imm        (d_imm),
    .sel_d      (d_sel_d),
    .sel_a      (d_sel_a),
    .sel_b      (d_sel_b),
    .is_mem     (d_is_mem),
    .is_write   (d_is_write),
    .is_branch  (d_is_branch),
    .writes_reg (d_writes_reg),
    .illegal    (d_illegal)
  );

  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      ST_FETCH:     if (bus.i_fetch_ack) next_state = ST_DECODE;
      ST_DECODE:    next_state = d_illegal ? ST_FETCH : ST_REGREAD;
      ST_REGREAD:   next_state = ST_EXECUTE;
      ST_EXECUTE:   next_state = d_is_mem ? ST_MEM : ST_WRITEBACK;
      ST_MEM: begin
        // An ack on the final counted cycle wins over the timeout
        if (bus.i_mem_ack) begin
          next_state = ST_WRITEBACK;
        end else if (mem_cnt == CNT_LAST) begin
          next_state = ST_FETCH;
          timeout    = 1'b1;
        end
      end
      ST_WRITEBACK: next_state = ST_FETCH;
      default:      next_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_FETCH;
      instr_q     <= '0;
      mem_cnt     <= '0;
      fetch_req   <= 1'b0;
      en_decode   <= 1'b0;
      en_regread  <= 1'b0;
      en_alu      <= 1'b0;
      en_regwrite <= 1'b0;
      aluop       <= '0;
      imm         <= '0;
      sel_d       <= '0;
      sel_a       <= '0;
      sel_b       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      wb_sel      <= 1'b0;
      pc_load     <= 1'b0;
      illegal     <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      state       <= next_state;
      mem_cnt     <= (state == ST_MEM && next_state == ST_MEM) ? mem_cnt + 8'd1 : 8'd0;
      fetch_req   <= (next_state == ST_FETCH);
      en_decode   <= (next_state == ST_DECODE);
      en_regread  <= (next_state == ST_REGREAD);
      en_alu      <= (next_state == ST_EXECUTE);
      mem_req     <= (next_state == ST_MEM);
      mem_we      <= (next_state == ST_MEM) && d_is_write;
      en_regwrite <= (next_state == ST_WRITEBACK) && d_writes_reg;
      wb_sel      <= (next_state == ST_WRITEBACK) && d_is_mem && !d_is_write;
      // Branch flag is only meaningful on the edge that ends EXECUTE
      pc_load     <= (state == ST_EXECUTE) && (next_state == ST_WRITEBACK) &&
                     d_is_branch && bus.i_shldBranch;
      illegal     <= (state == ST_FETCH) && (next_state == ST_DECODE) && d_illegal;
      mem_err     <= timeout;
      if (state == ST_FETCH && bus.i_fetch_ack) begin
        instr_q <= bus.i_instr;
        aluop   <= d_aluop;
        imm     <= d_imm;
        sel_d   <= d_sel_d;
        sel_a   <= d_sel_a;
        sel_b   <= d_sel_b;
      end
    end
  end

  assign bus.o_fetch_req   = fetch_req;
  assign bus.o_en_decode   = en_decode;
  assign bus.o_en_regread  = en_regread;
  assign bus.o_en_alu      = en_alu;
  assign bus.o_en_regwrite = en_regwrite;
  assign bus.o_aluop       = aluop;
  assign bus.o_imm         = imm;
  assign bus.o_selD        = sel_d;
  assign bus.o_selA        = sel_a;
  assign bus.o_selB        = sel_b;
  assign bus.o_mem_req     = mem_req;
  assign bus.o_mem_we      = mem_we;
  assign bus.o_wb_sel      = wb_sel;
  assign bus.o_pc_load     = pc_load;
  assign bus.o_illegal     = illegal;
  assign bus.o_mem_err     = mem_err;
endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Directed self-checking bench for control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  control_unit_if bus ();

  control_unit #(.MEM_TIMEOUT(15)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [32:0] all_outs;
  assign all_outs = {bus.o_fetch_req, bus.o_en_decode, bus.o_en_regread,
                     bus.o_en_alu, bus.o_en_regwrite, bus.o_aluop, bus.o_imm,
                     bus.o_selD, bus.o_selA, bus.o_selB, bus.o_mem_req,
                     bus.o_mem_we, bus.o_wb_sel, bus.o_pc_load, bus.o_illegal,
                     bus.o_mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word with an immediate ack; leaves the DUT in DECODE
  task automatic do_fetch(input logic [15:0] w);
    bus.i_instr     = w;
    bus.i_fetch_ack = 1'b1;
    tick();
    bus.i_fetch_ack = 1'b0;
    bus.i_instr     = 16'h0000;
  endtask

  task automatic test_reset();
    total++;
    if (all_outs !== 33'd0) begin
      bad++; $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    #2 rst_n = 1'b1;
    tick();
    total++;
    if ({bus.o_fetch_req, bus.o_en_decode} !== 2'b10) begin
      bad++; $display("FAIL reset_first_fetch: got %b expected 10", {bus.o_fetch_req, bus.o_en_decode});
    end
  endtask

  task automatic test_add();
    do_fetch(16'h014C);
    total++;
    if ({bus.o_en_decode, bus.o_aluop, bus.o_selD, bus.o_selA, bus.o_selB} !== {1'b1, 5'd0, 3'd1, 3'd2, 3'd3}) begin
      bad++; $display("FAIL add_decode: got %h expected %h",
        {bus.o_en_decode, bus.o_aluop, bus.o_selD, bus.o_selA, bus.o_selB}, {1'b1, 5'd0, 3'd1, 3'd2, 3'd3});
    end
    tick();
    total++;
    if ({bus.o_en_decode, bus.o_en_regread} !== 2'b01) begin
      bad++; $display("FAIL add_regread: got %b expected 01", {bus.o_en_decode, bus.o_en_regread});
    end
    tick();
    total++;
    if ({bus.o_en_regread, bus.o_en_alu} !== 2'b01) begin
      bad++; $display("FAIL add_execute: got %b expected 01", {bus.o_en_regread, bus.o_en_alu});
    end
    tick();
    total++;
    if ({bus.o_en_regwrite, bus.o_wb_sel, bus.o_pc_load, bus.o_mem_req, bus.o_en_alu} !== 5'b10000) begin
      bad++; $display("FAIL add_writeback: got %b expected 10000",
        {bus.o_en_regwrite, bus.o_wb_sel, bus.o_pc_load, bus.o_mem_req, bus.o_en_alu});
    end
    tick();
    total++;
    if ({bus.o_fetch_req, bus.o_en_regwrite} !== 2'b10) begin
      bad++; $display("FAIL add_refetch: got %b expected 10", {bus.o_fetch_req, bus.o_en_regwrite});
    end
  endtask

  task automatic test_load();
    do_fetch(16'h8AAB);
    total++;
    if ({bus.o_aluop, bus.o_imm, bus.o_selD} !== {5'b10001, 8'hAB, 3'd2}) begin
      bad++; $display("FAIL load_fields: got %h expected %h", {bus.o_aluop, bus.o_imm, bus.o_selD}, {5'b10001, 8'hAB, 3'd2});
    end
    tick(); tick(); tick();
    total++;
    if ({bus.o_en_regwrite, bus.o_wb_sel, bus.o_selD} !== {2'b10, 3'd2}) begin
      bad++; $display("FAIL load_writeback: got %b expected 10010", {bus.o_en_regwrite, bus.o_wb_sel, bus.o_selD});
    end
    tick();
  endtask

  task automatic test_branch(input logic taken);
    do_fetch(16'hC020);
    total++;
    if ({bus.o_aluop, bus.o_selA} !== {5'b11000, 3'd1}) begin
      bad++; $display("FAIL jmpa_fields: got %h expected %h", {bus.o_aluop, bus.o_selA}, {5'b11000, 3'd1});
    end
    tick(); tick();
    bus.i_shldBranch = taken;
    tick();
    bus.i_shldBranch = 1'b0;
    total++;
    if ({bus.o_pc_load, bus.o_en_regwrite} !== {taken, 1'b0}) begin
      bad++; $display("FAIL jmpa_pc_load(taken=%0b): got %b expected %b", taken,
        {bus.o_pc_load, bus.o_en_regwrite}, {taken, 1'b0});
    end
    tick();
    total++;
    if ({bus.o_pc_load, bus.o_fetch_req} !== 2'b01) begin
      bad++; $display("FAIL jmpa_pulse_end: got %b expected 01", {bus.o_pc_load, bus.o_fetch_req});
    end
  endtask

  task automatic test_wrmem();
    do_fetch(16'h7028);
    total++;
    if ({bus.o_aluop, bus.o_selA, bus.o_selB, bus.o_imm} !== {5'b01110, 3'd1, 3'd2, 8'h28}) begin
      bad++; $display("FAIL wrmem_fields: got %h expected %h",
        {bus.o_aluop, bus.o_selA, bus.o_selB, bus.o_imm}, {5'b01110, 3'd1, 3'd2, 8'h28});
    end
    tick(); tick(); tick();
    for (int c = 1; c <= 3; c++) begin
      total++;
      if ({bus.o_mem_req, bus.o_mem_we} !== 2'b11) begin
        bad++; $display("FAIL wrmem_req_cycle%0d: got %b expected 11", c, {bus.o_mem_req, bus.o_mem_we});
      end
      if (c == 3) bus.i_mem_ack = 1'b1;
      tick();
    end
    bus.i_mem_ack = 1'b0;
    total++;
    if ({bus.o_mem_req, bus.o_en_regwrite, bus.o_wb_sel, bus.o_mem_err} !== 4'b0000) begin
      bad++; $display("FAIL wrmem_writeback: got %b expected 0000",
        {bus.o_mem_req, bus.o_en_regwrite, bus.o_wb_sel, bus.o_mem_err});
    end
    tick();
  endtask

  task automatic test_timeout();
    do_fetch(16'h7028);
    tick(); tick(); tick();
    for (int c = 1; c <= 15; c++) begin
      total++;
      if ({bus.o_mem_req, bus.o_mem_err} !== 2'b10) begin
        bad++; $display("FAIL timeout_hold_cycle%0d: got %b expected 10", c, {bus.o_mem_req, bus.o_mem_err});
      end
      tick();
    end
    total++;
    if ({bus.o_mem_err, bus.o_fetch_req, bus.o_mem_req, bus.o_en_regwrite} !== 4'b1100) begin
      bad++; $display("FAIL timeout_err: got %b expected 1100",
        {bus.o_mem_err, bus.o_fetch_req, bus.o_mem_req, bus.o_en_regwrite});
    end
    tick();
    total++;
    if ({bus.o_mem_err, bus.o_fetch_req} !== 2'b01) begin
      bad++; $display("FAIL timeout_err_pulse: got %b expected 01", {bus.o_mem_err, bus.o_fetch_req});
    end
  endtask

  task automatic test_ack_at_timeout();
    do_fetch(16'h6128);
    total++;
    if ({bus.o_aluop, bus.o_selD} !== {5'b01100, 3'd1}) begin
      bad++; $display("FAIL rdmem_fields: got %h expected %h", {bus.o_aluop, bus.o_selD}, {5'b01100, 3'd1});
    end
    tick(); tick(); tick();
    repeat (14) tick();
    total++;
    if ({bus.o_mem_req, bus.o_mem_we} !== 2'b10) begin
      bad++; $display("FAIL rdmem_last_cycle: got %b expected 10", {bus.o_mem_req, bus.o_mem_we});
    end
    bus.i_mem_ack = 1'b1;
    tick();
    bus.i_mem_ack = 1'b0;
    total++;
    if ({bus.o_mem_err, bus.o_en_regwrite, bus.o_wb_sel, bus.o_mem_req} !== 4'b0110) begin
      bad++; $display("FAIL rdmem_late_ack: got %b expected 0110",
        {bus.o_mem_err, bus.o_en_regwrite, bus.o_wb_sel, bus.o_mem_req});
    end
    tick();
  endtask

  task automatic test_illegal();
    do_fetch(16'hE000);
    total++;
    if ({bus.o_en_decode, bus.o_illegal} !== 2'b11) begin
      bad++; $display("FAIL illegal_decode: got %b expected 11", {bus.o_en_decode, bus.o_illegal});
    end
    tick();
    total++;
    if ({bus.o_fetch_req, bus.o_illegal, bus.o_en_regread, bus.o_en_alu} !== 4'b1000) begin
      bad++; $display("FAIL illegal_refetch: got %b expected 1000",
        {bus.o_fetch_req, bus.o_illegal, bus.o_en_regread, bus.o_en_alu});
    end
    tick();
    total++;
    if ({bus.o_fetch_req, bus.o_en_alu} !== 2'b10) begin
      bad++; $display("FAIL illegal_no_alu: got %b expected 10", {bus.o_fetch_req, bus.o_en_alu});
    end
  endtask

  // Fetch ack held high throughout: fields must not be relatched outside FETCH
  task automatic test_back_to_back();
    bus.i_instr     = 16'h014C;
    bus.i_fetch_ack = 1'b1;
    tick();
    bus.i_instr = 16'h8AAB;
    tick();
    total++;
    if ({bus.o_en_regread, bus.o_aluop, bus.o_selD} !== {1'b1, 5'd0, 3'd1}) begin
      bad++; $display("FAIL b2b_hold_fields: got %h expected %h", {bus.o_en_regread, bus.o_aluop, bus.o_selD}, {1'b1, 5'd0, 3'd1});
    end
    tick(); tick();
    total++;
    if (bus.o_en_regwrite !== 1'b1) begin
      bad++; $display("FAIL b2b_writeback: got %b expected 1", bus.o_en_regwrite);
    end
    tick();
    tick();
    bus.i_fetch_ack = 1'b0;
    total++;
    if ({bus.o_en_decode, bus.o_aluop, bus.o_imm} !== {1'b1, 5'b10001, 8'hAB}) begin
      bad++; $display("FAIL b2b_second: got %h expected %h", {bus.o_en_decode, bus.o_aluop, bus.o_imm}, {1'b1, 5'b10001, 8'hAB});
    end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_mem();
    do_fetch(16'h7028);
    tick(); tick(); tick();
    total++;
    if (bus.o_mem_req !== 1'b1) begin
      bad++; $display("FAIL rst_mid_mem_pre: got %b expected 1", bus.o_mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (all_outs !== 33'd0) begin
      bad++; $display("FAIL rst_mid_mem_async: got %h expected 0", all_outs);
    end
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (bus.o_fetch_req !== 1'b1) begin
      bad++; $display("FAIL rst_mid_mem_refetch: got %b expected 1", bus.o_fetch_req);
    end
    test_add();
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    rst_n            = 1'b0;
    bus.i_instr      = 16'h0000;
    bus.i_fetch_ack  = 1'b0;
    bus.i_mem_ack    = 1'b0;
    bus.i_shldBranch = 1'b0;
    tick(); tick();
    test_reset();
    test_add();
    test_load();
    test_branch(1'b1);
    test_branch(1'b0);
    test_wrmem();
    test_timeout();
    test_ack_at_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer and instruction decoder for the 16-bit RISC core; it drives the ALU's opcode, immediate and enable inputs and consumes its branch flag. It fetches one instruction, steps it through decode, register read, execute, optional memory access and writeback, then emits per-stage enables, register selects and a PC-load strobe. Issue is one instruction at a time, with no pipelining.

## Interface
- MEM_TIMEOUT, 15: cycles in MEM without i_mem_ack before the access is abandoned (1–255).
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_instr  in  16  instruction word, valid while i_fetch_ack=1.
- i_fetch_ack  in  1  instruction memory accepted the fetch.
- i_mem_ack  in  1  data memory completed the access.
- i_shldBranch  in  1  ALU branch flag, valid at the rising edge that ends EXECUTE.
- o_fetch_req  out  1  request next instruction.
- o_en_decode / o_en_regread / o_en_alu / o_en_regwrite  out  1 each  stage enables.
- o_aluop  out  5  {opcode[3:0], signed/variant bit}.
- o_imm  out  8  immediate field.
- o_selD / o_selA / o_selB  out  3 each  destination and source register indices.
- o_mem_req  out  1  data memory request.
- o_mem_we  out  1  1 = write (Wrmem), 0 = read (Rdmem).
- o_wb_sel  out  1  writeback source: 0 = ALU result, 1 = memory data.
- o_pc_load  out  1  one-cycle strobe: load PC from ALU result.
- o_illegal  out  1  one-cycle strobe for opcode 14 or 15.
- o_mem_err  out  1  one-cycle strobe when MEM times out.

## Operation
- Instruction fields: aluop=[15:11], rD=[10:8], rA=[7:5], rB=[4:2], imm=[7:0]. Opcodes: Add0 Sub1 OR2 AND3 XOR4 NOT5 Rdmem6 Wrmem7 Load8 Cmp9 SHL10 SHR11 JMPA12 JMPR13.
- States: FETCH → DECODE → REGREAD → EXECUTE → {MEM | WRITEBACK} → FETCH.
- FETCH: o_fetch_req=1 until i_fetch_ack. On ack, latch i_instr and go to DECODE.
- DECODE: o_en_decode=1. Opcode 14 or 15 pulses o_illegal and returns to FETCH.
- REGREAD: o_en_regread=1.
- EXECUTE: o_en_alu=1. Rdmem/Wrmem go to MEM; all other opcodes go to WRITEBACK.
- MEM: o_mem_req=1, o_mem_we per opcode, timeout counter running.
  - On i_mem_ack, go to WRITEBACK.
  - After MEM_TIMEOUT cycles without ack, pulse o_mem_err, skip writeback, go to FETCH.
- WRITEBACK:
  - o_en_regwrite=1 for opcodes 0–6 and 8–11; o_wb_sel=1 only for Rdmem.
  - For JMPA/JMPR, o_pc_load = i_shldBranch sampled at the end of EXECUTE, with no regwrite.
  - Wrmem: no regwrite.
- o_aluop, o_imm and the selects hold the latched instruction fields from DECODE until the next fetch ack.
- All outputs are registered, decoded from the next state.

## Timing
- Reset (async, any state): state=FETCH and every output=0. After release, o_fetch_req rises on the first clock edge.
- Non-memory instruction with ack in the first FETCH cycle takes 5 cycles. A memory instruction takes 5 cycles plus MEM cycles.
- The ALU captures on the falling edge inside EXECUTE, so its result and i_shldBranch are stable at the edge that ends EXECUTE.
- i_fetch_ack outside FETCH and i_mem_ack outside MEM are ignored.
- An ack in the same cycle the timeout expires counts as success; o_mem_err is not raised.
- Reset asserted mid-MEM drops o_mem_req immediately, asynchronously.

## Structure
- Shared package ctrl_pkg holds:
  - opcode localparams (same numbering as the ALU);
  - state encoding;
  - instruction field bit positions;
  - writeback-class and branch-class masks.
- One sub-module, instr_decoder: purely combinational field extraction plus the is_mem, is_write, is_branch, writes_reg and illegal flags.

## Test plan
- ADD r1,r2,r3: i_instr=16'h014C with immediate ack → o_aluop=0, selD=1, selA=2, selB=3; o_en_regwrite high in cycle 5 with o_wb_sel=0.
- LOAD high r2,#0xAB: 16'h8AAB → o_aluop=5'b10001, o_imm=8'hAB, regwrite to r2.
- JMPA #0x20: 16'hC020 with i_shldBranch=1 → o_pc_load pulses for one cycle and no regwrite. With i_shldBranch=0 → no pulse.
- Wrmem: 16'h7028 with i_mem_ack after 3 cycles → o_mem_req high 3 cycles, o_mem_we=1, no regwrite. Withholding ack for 15 cycles → o_mem_err pulse, then FETCH.
- Illegal 16'hE000 → o_illegal pulse in DECODE, no o_en_alu, next o_fetch_req.
- i_rst_n low during MEM → all outputs 0 without a clock edge; after release, a clean fetch of 16'h014C behaves as in the first scenario.
